// File: rtl/chess_pkg.sv
// Shared chess constants: piece codes, sequencer state encoding and moveData layout.
package chess_pkg;
  localparam logic [3:0] EMPTY      = 4'd0;
  localparam int         COLOUR_BIT = 3;
  localparam logic       WHITE      = 1'b0;
  localparam logic       BLACK      = 1'b1;

  localparam logic [1:0] SEL_SRC = 2'd0;
  localparam logic [1:0] SEL_DST = 2'd1;
  localparam logic [1:0] REQ     = 2'd2;

  localparam int MD_DST_LSB  = 0;
  localparam int MD_SRC_LSB  = 6;
  localparam int MD_TURN_BIT = 12;

  function automatic logic isOwn(input logic [3:0] piece, input logic side);
    return (piece != EMPTY) && (piece[COLOUR_BIT] == side);
  endfunction

  // One cursor step along a single axis, wrapping or saturating at the board edge.
  function automatic logic [2:0] stepCoord(input logic [2:0] v, input logic inc, input logic wrap);
    if (inc) begin
      if (v == 3'd7) return wrap ? 3'd0 : 3'd7;
      return v + 3'd1;
    end
    if (v == 3'd0) return wrap ? 3'd7 : 3'd0;
    return v - 3'd1;
  endfunction
endpackage

// File: rtl/press_detect.sv
// Registers one debounced button level and flags its rising edge as a press.
module press_detect (
  input  logic clk,
  input  logic reset,
  input  logic level,
  output logic press
);
  logic prev;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) prev <= 1'b0;
    else        prev <= level;
  end

  assign press = level & ~prev;
endmodule

// File: rtl/move_sequencer.sv
// Button-driven cursor, source/destination selection and move-commit handshake for the chess game.
//   state   | meaning
//   SEL_SRC | choose a piece of the side to move
//   SEL_DST | choose target square (or reselect / cancel)
//   REQ     | move_req held, waiting for board verdict or timeout
module move_sequencer
  import chess_pkg::*;
#(
  parameter int ACK_TIMEOUT = 1023,
  parameter bit WRAP        = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BTNC,
  input  logic        BTNU,
  input  logic        BTND,
  input  logic        BTNL,
  input  logic        BTNR,
  input  logic [3:0]  sq_piece,
  input  logic        move_ack,
  input  logic        move_ok,
  output logic [5:0]  cursor,
  output logic        turn,
  output logic [1:0]  phase,
  output logic        move_req,
  output logic [12:0] moveData,
  output logic        error
);
  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  logic          pressC, pressU, pressD, pressL, pressR;
  logic [1:0]    state;
  logic [5:0]    src, dst, nextCursor;
  logic [CW-1:0] ackCount;
  logic          own;

  press_detect pdC (.clk(clk), .reset(reset), .level(BTNC), .press(pressC));
  press_detect pdU (.clk(clk), .reset(reset), .level(BTNU), .press(pressU));
  press_detect pdD (.clk(clk), .reset(reset), .level(BTND), .press(pressD));
  press_detect pdL (.clk(clk), .reset(reset), .level(BTNL), .press(pressL));
  press_detect pdR (.clk(clk), .reset(reset), .level(BTNR), .press(pressR));

  assign own = isOwn(sq_piece, turn);

  // Priority chain: a centre press suppresses every direction in the same cycle.
  always_comb begin
    nextCursor = cursor;
    if (!pressC) begin
      if (pressU)      nextCursor[5:3] = stepCoord(cursor[5:3], 1'b1, WRAP);
      else if (pressD) nextCursor[5:3] = stepCoord(cursor[5:3], 1'b0, WRAP);
      else if (pressL) nextCursor[2:0] = stepCoord(cursor[2:0], 1'b0, WRAP);
      else if (pressR) nextCursor[2:0] = stepCoord(cursor[2:0], 1'b1, WRAP);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= SEL_SRC;
      cursor   <= 6'd0;
      turn     <= WHITE;
      src      <= 6'd0;
      dst      <= 6'd0;
      ackCount <= '0;
      error    <= 1'b0;
    end else begin
      error <= 1'b0;
      case (state)
        SEL_SRC: begin
          cursor <= nextCursor;
          if (pressC) begin
            if (own) begin
              src   <= cursor;
              state <= SEL_DST;
            end else begin
              error <= 1'b1;
            end
          end
        end
        SEL_DST: begin
          cursor <= nextCursor;
          if (pressC) begin
            if (cursor == src) begin
              state <= SEL_SRC;
            end else if (own) begin
              src <= cursor;
            end else begin
              dst      <= cursor;
              ackCount <= '0;
              state    <= REQ;
            end
          end
        end
        REQ: begin
          // An ack on the final timeout cycle still counts as a verdict.
          if (move_ack) begin
            state <= SEL_SRC;
            if (move_ok) turn  <= (turn == WHITE) ? BLACK : WHITE;
            else         error <= 1'b1;
          end else if (ackCount == CW'(ACK_TIMEOUT)) begin
            state <= SEL_SRC;
            error <= 1'b1;
          end else begin
            ackCount <= ackCount + CW'(1);
          end
        end
        default: state <= SEL_SRC;
      endcase
    end
  end

  assign move_req = (state == REQ);
  assign phase    = state;
  assign moveData[MD_TURN_BIT]      = turn;
  assign moveData[MD_SRC_LSB +: 6]  = src;
  assign moveData[MD_DST_LSB +: 6]  = dst;
endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: behavioural chess-UI model predicts every cycle and every request.
module tb_move_sequencer;
  localparam int ACK_TO = 7;

  logic        clk = 1'b0;
  logic        reset;
  logic        BTNC, BTNU, BTND, BTNL, BTNR;
  logic [3:0]  sq_piece;
  logic        move_ack, move_ok;
  logic [5:0]  cursor;
  logic        turn;
  logic [1:0]  phase;
  logic        move_req;
  logic [12:0] moveData;
  logic        error;

  always #5 clk = ~clk;

  move_sequencer #(.ACK_TIMEOUT(ACK_TO), .WRAP(1'b1)) dut (
    .clk(clk), .reset(reset),
    .BTNC(BTNC), .BTNU(BTNU), .BTND(BTND), .BTNL(BTNL), .BTNR(BTNR),
    .sq_piece(sq_piece), .move_ack(move_ack), .move_ok(move_ok),
    .cursor(cursor), .turn(turn), .phase(phase), .move_req(move_req),
    .moveData(moveData), .error(error)
  );

  typedef struct packed {
    logic [5:0]  cur;
    logic        turn;
    logic [1:0]  ph;
    logic        req;
    logic [12:0] md;
    logic        err;
  } expT;

  expT         expQ[$];
  logic [12:0] reqQ[$];
  int          checks = 0;
  int          errors = 0;
  logic        lastReq = 1'b0;
  logic [3:0]  boardArr[64];

  // Reference model: board coordinates as plain integers, phase as the display code.
  int         mRow, mCol, mPhase, mReqCycles;
  logic       mTurn;
  logic [5:0] mSrc, mDst;
  logic [4:0] mPrev;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic modelReset();
    mRow = 0; mCol = 0; mPhase = 0; mReqCycles = 0;
    mTurn = 1'b0; mSrc = 6'd0; mDst = 6'd0; mPrev = 5'd0;
  endtask

  function automatic int mv(input int v, input int d);
    return (v + d + 8) % 8;
  endfunction

  // lv bits: 4=C 3=U 2=D 1=L 0=R
  task automatic step(input logic [4:0] lv, input logic ack, input logic ok);
    logic [5:0] cur;
    logic [4:0] pr;
    logic [3:0] pc;
    logic       err, own;
    expT        e;
    @(negedge clk);
    {BTNC, BTNU, BTND, BTNL, BTNR} = lv;
    move_ack = ack;
    move_ok  = ok;
    cur      = 6'(mRow * 8 + mCol);
    pc       = boardArr[cur];
    sq_piece = pc;
    pr    = lv & ~mPrev;
    mPrev = lv;
    err   = 1'b0;
    own   = (pc != 4'd0) && (pc[3] == mTurn);
    if (mPhase == 2) begin
      if (ack) begin
        if (ok) mTurn = ~mTurn;
        else    err = 1'b1;
        mPhase = 0;
      end else if (mReqCycles == ACK_TO + 1) begin
        err    = 1'b1;
        mPhase = 0;
      end else begin
        mReqCycles++;
      end
    end else if (pr[4]) begin
      if (mPhase == 0) begin
        if (own) begin mSrc = cur; mPhase = 1; end
        else err = 1'b1;
      end else if (cur == mSrc) begin
        mPhase = 0;
      end else if (own) begin
        mSrc = cur;
      end else begin
        mDst = cur; mPhase = 2; mReqCycles = 1;
        reqQ.push_back({mTurn, mSrc, mDst});
      end
    end else if (pr[3]) mRow = mv(mRow, 1);
    else if (pr[2])     mRow = mv(mRow, -1);
    else if (pr[1])     mCol = mv(mCol, -1);
    else if (pr[0])     mCol = mv(mCol, 1);
    e.cur  = 6'(mRow * 8 + mCol);
    e.turn = mTurn;
    e.ph   = 2'(mPhase);
    e.req  = (mPhase == 2);
    e.md   = {mTurn, mSrc, mDst};
    e.err  = err;
    expQ.push_back(e);
  endtask

  task automatic tap(input int idx);
    step(5'(1 << idx), 1'b0, 1'b0);
  endtask

  task automatic rel();
    step(5'd0, 1'b0, 1'b0);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic gotoSq(input logic [5:0] target);
    for (int k = 0; k < 20; k++) begin
      if (6'(mRow * 8 + mCol) == target) break;
      if (mRow < int'(target[5:3]))      tap(3);
      else if (mRow > int'(target[5:3])) tap(2);
      else if (mCol < int'(target[2:0])) tap(0);
      else                               tap(1);
      rel();
    end
  endtask

  initial begin : monitor
    expT e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        chk("cursor",   cursor,   e.cur);
        chk("turn",     turn,     e.turn);
        chk("phase",    phase,    e.ph);
        chk("move_req", move_req, e.req);
        chk("moveData", moveData, e.md);
        chk("error",    error,    e.err);
      end
      if (move_req && !lastReq) begin
        if (reqQ.size() > 0) chk("req_moveData", moveData, reqQ.pop_front());
        else                 chk("req_unexpected", move_req, 1'b0);
      end
      lastReq = move_req;
    end
  end

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog time limit reached t=%0t", $time);
    $fatal(1);
  end

  initial begin : driver
    {BTNC, BTNU, BTND, BTNL, BTNR} = 5'd0;
    move_ack = 1'b0; move_ok = 1'b0; sq_piece = 4'd0; reset = 1'b0;
    for (int i = 0; i < 64; i++) boardArr[i] = 4'd0;
    modelReset();
    #12;
    chk("rst_cursor",   cursor,   6'd0);
    chk("rst_turn",     turn,     1'b0);
    chk("rst_phase",    phase,    2'd0);
    chk("rst_move_req", move_req, 1'b0);
    chk("rst_moveData", moveData, 13'd0);
    chk("rst_error",    error,    1'b0);
    @(negedge clk);
    reset = 1'b1;

    tap(3); rel(); tap(3); rel(); tap(0); rel();
    settle(); chk("nav_UUR", cursor, 6'o21);
    tap(1); rel(); tap(1); rel();
    settle(); chk("nav_wrap_L", cursor, 6'o27);

    boardArr[6'o14] = 4'h1;
    boardArr[6'o13] = 4'h2;
    boardArr[6'o64] = 4'h9;

    gotoSq(6'o00); tap(4);
    settle(); chk("err_empty", error, 1'b1); chk("err_empty_phase", phase, 2'd0);
    rel();
    gotoSq(6'o64); tap(4);
    settle(); chk("err_opp", error, 1'b1); chk("err_opp_phase", phase, 2'd0);
    rel();

    gotoSq(6'o14); tap(4); rel();
    settle(); chk("sel_src_phase", phase, 2'd1);
    tap(4);
    settle(); chk("cancel_phase", phase, 2'd0); chk("cancel_noerr", error, 1'b0);
    rel(); tap(4); rel();
    gotoSq(6'o13); tap(4);
    settle(); chk("resel_src", moveData[11:6], 6'o13); chk("resel_phase", phase, 2'd1);
    rel();
    gotoSq(6'o14); tap(4); rel();
    gotoSq(6'o34); tap(4);
    settle(); chk("req_high", move_req, 1'b1);
    chk("req_data", moveData, {1'b0, 6'o14, 6'o34});
    rel(); rel();
    step(5'd0, 1'b1, 1'b1);
    settle(); chk("ack_req_low", move_req, 1'b0); chk("ack_turn", turn, 1'b1);

    // Black to move: timeout path, then ack on the last permitted cycle.
    gotoSq(6'o64); tap(4); rel();
    gotoSq(6'o44); tap(4);
    for (int i = 0; i < ACK_TO; i++) rel();
    settle(); chk("to_req_still_high", move_req, 1'b1);
    rel();
    settle(); chk("to_req_low", move_req, 1'b0); chk("to_error", error, 1'b1);
    chk("to_turn", turn, 1'b1);
    rel();
    gotoSq(6'o64); tap(4); rel();
    gotoSq(6'o54); tap(4);
    for (int i = 0; i < ACK_TO; i++) rel();
    step(5'd0, 1'b1, 1'b1);
    settle(); chk("lastack_req_low", move_req, 1'b0); chk("lastack_noerr", error, 1'b0);
    chk("lastack_turn", turn, 1'b0);

    gotoSq(6'o14); tap(4); rel();
    gotoSq(6'o24); tap(4); rel(); rel();
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_move_req", move_req, 1'b0);
    chk("midrst_cursor",   cursor,   6'd0);
    chk("midrst_turn",     turn,     1'b0);
    chk("midrst_phase",    phase,    2'd0);
    chk("midrst_moveData", moveData, 13'd0);
    chk("midrst_error",    error,    1'b0);
    modelReset();
    {BTNC, BTNU, BTND, BTNL, BTNR} = 5'd0;
    move_ack = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 64; i++)
      boardArr[i] = ($urandom_range(1) == 0) ? 4'd0 : 4'($urandom_range(15));
    for (int n = 0; n < 3000; n++) begin
      logic [4:0] lv;
      logic       ack;
      for (int b = 0; b < 5; b++) lv[b] = ($urandom_range(3) == 0);
      ack = (mPhase == 2) ? ($urandom_range(9) == 0) : ($urandom_range(30) == 0);
      step(lv, ack, 1'($urandom_range(1)));
    end
    rel(); rel();
    @(posedge clk);
    #3;
    chk("req_queue_drained", reqQ.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
